// File: rtl/branch_target_buffer_n.sv
// branch_target_buffer_n: direct-mapped BTB with 2-bit counters and a registered lookup.
// Define BTB_BYPASS_EN to forward a same-index update into the same-cycle lookup.
module branch_target_buffer_n #(
    parameter int         ENTRIES  = 16,
    parameter logic [1:0] CTR_INIT = 2'b10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] PC_in,
    input  logic        access,
    input  logic        update,
    input  logic [31:0] update_PC,
    input  logic [31:0] branch_target,
    input  logic        taken,
    output logic [31:0] predictPC,
    output logic        predict_taken,
    output logic        hit,
    output logic [1:0]  state
);
    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = 30 - IDX_W;

    logic             valid   [ENTRIES];
    logic [TAG_W-1:0] tags    [ENTRIES];
    logic [31:0]      targets [ENTRIES];
    logic [1:0]       ctrs    [ENTRIES];

    logic [IDX_W-1:0] l_idx, u_idx;
    logic [TAG_W-1:0] l_tag, u_tag, r_tag;
    logic [31:0]      u_target, r_target;
    logic [1:0]       u_ctr, r_ctr;
    logic             u_hit, u_we, r_valid, r_hit, r_taken;
    logic             unused_pc_bits;

    assign l_idx = PC_in[IDX_W+1:2];
    assign l_tag = PC_in[31:IDX_W+2];
    assign u_idx = update_PC[IDX_W+1:2];
    assign u_tag = update_PC[31:IDX_W+2];
    assign unused_pc_bits = ^{PC_in[1:0], update_PC[1:0]};

    // A not-taken miss trains nothing, so only hits and taken misses write.
    assign u_hit    = valid[u_idx] && tags[u_idx] == u_tag;
    assign u_we     = update && (u_hit || taken);
    assign u_target = taken ? branch_target : targets[u_idx];

    always_comb begin
        u_ctr = CTR_INIT;
        if (u_hit)
            u_ctr = taken ? (ctrs[u_idx] == 2'b11 ? 2'b11 : ctrs[u_idx] + 2'd1)
                          : (ctrs[u_idx] == 2'b00 ? 2'b00 : ctrs[u_idx] - 2'd1);
    end

`ifdef BTB_BYPASS_EN
    logic bypass;
    assign bypass   = u_we && u_idx == l_idx;
    assign r_valid  = bypass || valid[l_idx];
    assign r_tag    = bypass ? u_tag    : tags[l_idx];
    assign r_target = bypass ? u_target : targets[l_idx];
    assign r_ctr    = bypass ? u_ctr    : ctrs[l_idx];
`else
    assign r_valid  = valid[l_idx];
    assign r_tag    = tags[l_idx];
    assign r_target = targets[l_idx];
    assign r_ctr    = ctrs[l_idx];
`endif

    assign r_hit   = r_valid && r_tag == l_tag;
    assign r_taken = r_hit && r_ctr[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid[i] <= 1'b0;
                ctrs[i]  <= 2'b00;
            end
        end else if (u_we) begin
            valid[u_idx] <= 1'b1;
            ctrs[u_idx]  <= u_ctr;
        end
    end

    // Tags and targets are only meaningful behind a valid bit, so they stay unreset.
    always_ff @(posedge clk) begin
        if (u_we) begin
            tags[u_idx]    <= u_tag;
            targets[u_idx] <= u_target;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            predictPC     <= 32'd0;
            predict_taken <= 1'b0;
            hit           <= 1'b0;
            state         <= 2'b00;
        end else if (access) begin
            predictPC     <= r_taken ? r_target : PC_in + 32'd4;
            predict_taken <= r_taken;
            hit           <= r_hit;
            state         <= r_hit ? r_ctr : 2'b00;
        end
    end
endmodule
